// File: rtl/rc_pkg.sv
// RC arm controller shared package: FSM state encoding, channel map
// and pulse-width limits used by the controller and its timebase.
package rc_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2,
        ST_FAILSAFE = 2'd3
    } rc_state_e;

    localparam int NUM_CH = 6;
    localparam int CH_THR = 2;
    localparam int CH_YAW = 3;

    localparam logic [15:0] PW_MIN  = 16'd900;
    localparam logic [15:0] THR_LO  = 16'd1000;
    localparam logic [15:0] GEST_LO = 16'd1100;
    localparam logic [15:0] GEST_HI = 16'd1900;
    localparam logic [15:0] THR_HI  = 16'd2000;
    localparam logic [15:0] PW_MAX  = 16'd2100;

    function automatic logic [15:0] thr_clamp(
        input logic [15:0] v
    );
        if (v < THR_LO)
            return THR_LO;
        else if (v > THR_HI)
            return THR_HI;
        else
            return v;
    endfunction

endpackage

// File: rtl/rc_us_timebase.sv
// Microsecond timebase: free-running divider, one-cycle tick
// every CLK_PER_US clocks.
// Ports: clk, rst_n (sync, active-low), tick (1-cycle pulse).
module rc_us_timebase #(
    parameter int CLK_PER_US = 50
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DW =
        (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_PER_US - 1);

    logic [DW-1:0] div_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            div_q <= '0;
        else if (div_q == LAST)
            div_q <= '0;
        else
            div_q <= div_q + DW'(1);
    end

    assign tick = (div_q == LAST);

endmodule

// File: rtl/rc_arm_controller.sv
// RC arm/disarm controller: validates PPM frames, detects stick
// gestures held for ARM_HOLD_FRAMES frames, gates throttle output.
// Optional frame-loss failsafe enabled by macro RC_ARM_FAILSAFE_EN.
// Ports: clk, rst_n (sync, active-low), ch[0:5] pulse widths in us,
// frame_stb, state, armed, failsafe, thr_cmd, frame_ok, err_cnt.
module rc_arm_controller
    import rc_pkg::*;
#(
    parameter int CLK_PER_US       = 50,
    parameter int FRAME_TIMEOUT_US = 50000,
    parameter int ARM_HOLD_FRAMES  = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ch [0:NUM_CH-1],
    input  logic        frame_stb,
    output logic [1:0]  state,
    output logic        armed,
    output logic        failsafe,
    output logic [15:0] thr_cmd,
    output logic        frame_ok,
    output logic [7:0]  err_cnt
);

    localparam int HW = $clog2(ARM_HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_LAST =
        HW'(ARM_HOLD_FRAMES);

    rc_state_e     state_q, state_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic [15:0]   thr_q, thr_d;
    logic [7:0]    err_q, err_d;
    logic          ok_q;
    logic          all_ok, acc, timeout, us_tick;
    logic          g_arm, g_dis, thr_low;
    logic [15:0]   thr, yaw;

    rc_us_timebase #(
        .CLK_PER_US(CLK_PER_US)
    ) u_tb (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (us_tick)
    );

    always_comb begin
        all_ok = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (ch[i] < PW_MIN || ch[i] > PW_MAX)
                all_ok = 1'b0;
    end

    assign acc     = frame_stb && all_ok;
    assign thr     = ch[CH_THR];
    assign yaw     = ch[CH_YAW];
    assign thr_low = (thr <= GEST_LO);
    assign g_arm   = thr_low && (yaw >= GEST_HI);
    assign g_dis   = thr_low && (yaw <= GEST_LO);

`ifdef RC_ARM_FAILSAFE_EN
    localparam int UW = $clog2(FRAME_TIMEOUT_US + 1);
    localparam logic [UW-1:0] US_LAST =
        UW'(FRAME_TIMEOUT_US);

    logic [UW-1:0] us_q;

    // Saturates at the timeout so FAILSAFE stays latched
    // until a frame arrives.
    always_ff @(posedge clk) begin
        if (!rst_n)
            us_q <= '0;
        else if (acc)
            us_q <= '0;
        else if (us_tick && us_q != US_LAST)
            us_q <= us_q + UW'(1);
    end

    assign timeout = (us_q == US_LAST) &&
                     (state_q != ST_FAILSAFE);
`else
    logic unused_tb;
    assign unused_tb = us_tick ^ (FRAME_TIMEOUT_US > 0);
    assign timeout   = 1'b0;
`endif

    // State, hold count and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_DISARMED;
            hold_q  <= '0;
            thr_q   <= THR_LO;
            err_q   <= 8'd0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            thr_q   <= thr_d;
            err_q   <= err_d;
            ok_q    <= acc;
        end
    end

    // Next state; an accepted frame outranks a timeout
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        hold_inc = hold_q + HW'(1);
        if (acc) begin
            unique case (state_q)
                ST_DISARMED: begin
                    if (g_arm) begin
                        state_d = ST_ARMING;
                        hold_d  = HW'(1);
                    end
                end
                ST_ARMING: begin
                    if (!g_arm) begin
                        state_d = ST_DISARMED;
                        hold_d  = '0;
                    end else if (hold_inc == HOLD_LAST) begin
                        state_d = ST_ARMED;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_inc;
                    end
                end
                ST_ARMED: begin
                    if (!g_dis) begin
                        hold_d  = '0;
                    end else if (hold_inc == HOLD_LAST) begin
                        state_d = ST_DISARMED;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_inc;
                    end
                end
                ST_FAILSAFE: begin
                    if (thr_low) begin
                        state_d = ST_DISARMED;
                        hold_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                    hold_d  = '0;
                end
            endcase
        end else if (timeout) begin
            state_d = ST_FAILSAFE;
            hold_d  = '0;
        end
    end

    // Throttle follows the stick only while staying ARMED
    always_comb begin
        thr_d = thr_q;
        if (state_d != ST_ARMED)
            thr_d = THR_LO;
        else if (acc && state_q == ST_ARMED)
            thr_d = thr_clamp(thr);
    end

    always_comb begin
        err_d = err_q;
        if (frame_stb && !all_ok && err_q != 8'hFF)
            err_d = err_q + 8'd1;
    end

    // Outputs decoded from registered state
    always_comb begin
        state    = state_q;
        armed    = (state_q == ST_ARMED);
`ifdef RC_ARM_FAILSAFE_EN
        failsafe = (state_q == ST_FAILSAFE);
`else
        failsafe = 1'b0;
`endif
        thr_cmd  = thr_q;
        frame_ok = ok_q;
        err_cnt  = err_q;
    end

endmodule

// File: doc/rc_arm_controller.md
RC_ARM_CONTROLLER -- requirements
Module: rc_arm_controller

Interface
REQ-001 Parameter CLK_PER_US, 50, clk cycles per microsecond (50 MHz clk).
REQ-002 Parameter FRAME_TIMEOUT_US, 50000, max µs between accepted frames before failsafe.
REQ-003 Parameter ARM_HOLD_FRAMES, 50, consecutive accepted frames a stick gesture must persist.
REQ-004 Port clk  input  1  sole clock; one clock, all logic on posedge clk.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port ch  input  16 x [0:5]  decoded PPM channel pulse widths in µs, stable when frame_stb high.
REQ-007 Port frame_stb  input  1  one-cycle strobe: new frame present on ch.
REQ-008 Port state  output  2  current FSM state encoding.
REQ-009 Port armed  output  1  high only in ARMED.
REQ-010 Port failsafe  output  1  high only in FAILSAFE.
REQ-011 Port thr_cmd  output  16  throttle command in µs to motor PWM stage.
REQ-012 Port frame_ok  output  1  one-cycle pulse per accepted frame.
REQ-013 Port err_cnt  output  8  saturating count of rejected frames.

Function
REQ-014 Channel map: ch[2] throttle, ch[3] yaw; frame accepted iff frame_stb and all six ch in [900,2100] inclusive; otherwise rejected, err_cnt += 1, saturating at 255.
REQ-015 Gestures on accepted frames: ARM = thr <= 1100 and yaw >= 1900; DISARM = thr <= 1100 and yaw <= 1100.
REQ-016 States: DISARMED=0, ARMING=1, ARMED=2, FAILSAFE=3.
REQ-017 DISARMED: accepted ARM frame -> ARMING, hold_cnt = 1.
REQ-018 ARMING: accepted ARM frame -> hold_cnt += 1; hold_cnt reaching ARM_HOLD_FRAMES -> ARMED, hold_cnt = 0; accepted non-ARM frame -> DISARMED, hold_cnt = 0.
REQ-019 ARMED: accepted DISARM frames counted identically; ARM_HOLD_FRAMES consecutive -> DISARMED; any other accepted frame clears count.
REQ-020 FAILSAFE: accepted frame with thr <= 1100 -> DISARMED; any other accepted frame stays FAILSAFE; never direct to ARMED.
REQ-021 Rejected frames do not alter state or hold_cnt, and do not restart timeout.
REQ-022 Timeout: internal µs tick every CLK_PER_US cycles; µs counter cleared by accepted frame, incremented per tick, saturating; reaching FRAME_TIMEOUT_US in any non-FAILSAFE state -> FAILSAFE, hold_cnt = 0.
REQ-023 Accepted frame and timeout in same cycle: frame wins, timeout suppressed.
REQ-024 thr_cmd: in ARMED, updated on each accepted frame to throttle clamped to [1000,2000]; in every other state forced to 1000.
REQ-025 Latency: frame_stb at cycle N -> state, thr_cmd, frame_ok, err_cnt updated at N+1; armed/failsafe decoded from registered state.

Reset
REQ-026 rst_n low at posedge: state = DISARMED, hold_cnt = 0, µs counter and divider = 0, thr_cmd = 1000, armed = 0, failsafe = 0, frame_ok = 0, err_cnt = 0.
REQ-027 Reset asserted mid-ARMING or ARMED aborts immediately; no residual hold count survives.

Configuration
REQ-028 Macro RC_ARM_FAILSAFE_EN defined: timeout logic and FAILSAFE state per REQ-020..023.
REQ-029 Macro absent: no µs counter, FAILSAFE unreachable, failsafe tied 0, loss of frames holds current state and thr_cmd.

Structure
REQ-030 Package rc_pkg holds state enum, channel index constants (CH_THR=2, CH_YAW=3), limits 900/1000/1100/1900/2000/2100.
REQ-031 Sub-module rc_us_timebase: divider emitting a one-cycle µs tick every CLK_PER_US cycles.

Verification
REQ-032 Reset, then 50 frames thr=1000 yaw=2000 -> ARMING after frame 1, ARMED the cycle after frame 50, thr_cmd=1000.
REQ-033 ARMED, frame thr=2500 on ch[2] -> rejected, err_cnt=1, thr_cmd unchanged; frame thr=1500 -> thr_cmd=1500 at N+1.
REQ-034 ARMING after 20 frames, one frame yaw=1500 -> DISARMED, hold_cnt=0.
REQ-035 ARMED, frames stopped 50000 µs -> FAILSAFE, thr_cmd=1000; frame thr=1500 stays FAILSAFE; frame thr=1000 -> DISARMED.
REQ-036 Frame strobe coincident with timeout cycle -> no FAILSAFE; rst_n low during ARMING at hold_cnt=30 -> DISARMED, all outputs at reset values next cycle.
